// File: rtl/axi_lite_regfile_slv.sv
// axi_lite_regfile_slv: AXI4-Lite slave register bank with byte strobes, exported flat on reg_o.
// Define AXI_LITE_REGFILE_RO_EN to make registers flagged in RO_MASK reject writes with SLVERR.
module axi_lite_regfile_slv #(
    parameter int AXI_ADDR_WIDTH = 3,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0]          aw_addr_i,
    input  logic [2:0]                         aw_prot_i,
    input  logic                               aw_valid_i,
    output logic                               aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]          w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]        w_strb_i,
    input  logic                               w_valid_i,
    output logic                               w_ready_o,
    output logic [1:0]                         b_resp_o,
    output logic                               b_valid_o,
    input  logic                               b_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]          ar_addr_i,
    input  logic [2:0]                         ar_prot_i,
    input  logic                               ar_valid_i,
    output logic                               ar_ready_o,
    output logic [AXI_DATA_WIDTH-1:0]          r_data_o,
    output logic [1:0]                         r_resp_o,
    output logic                               r_valid_o,
    input  logic                               r_ready_i,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_o
);
    localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IW = AXI_ADDR_WIDTH - OFF;
    localparam int SW = AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_state_n;
    r_state_t r_state, r_state_n;
    logic aw_held, w_held;
    logic [IW-1:0] aw_idx_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic aw_fire, w_fire, ar_fire, commit, w_err, r_err;
    logic [IW-1:0] w_idx, r_idx;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic unused_ok;

    assign unused_ok = ^{aw_prot_i, ar_prot_i, aw_addr_i, ar_addr_i, RO_MASK};

    // Readies are gated by rst_i so they stay low while reset is asserted.
    always_comb begin
        aw_ready_o = w_state == W_IDLE && !aw_held && !rst_i;
        w_ready_o  = w_state == W_IDLE && !w_held && !rst_i;
        b_valid_o  = w_state == W_RESP;
        aw_fire    = aw_valid_i && aw_ready_o;
        w_fire     = w_valid_i && w_ready_o;
        w_idx      = aw_held ? aw_idx_q : aw_addr_i[AXI_ADDR_WIDTH-1:OFF];
        w_data     = w_held ? w_data_q : w_data_i;
        w_strb     = w_held ? w_strb_q : w_strb_i;
        commit     = (aw_held || aw_fire) && (w_held || w_fire);
        w_err      = 32'(w_idx) >= NUM_REGS;
`ifdef AXI_LITE_REGFILE_RO_EN
        if (!w_err) w_err = RO_MASK[w_idx];
`endif
        w_state_n  = w_state == W_IDLE ? (commit ? W_RESP : W_IDLE) : (b_ready_i ? W_IDLE : W_RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            b_resp_o <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state <= w_state_n;
            aw_held <= (aw_held || aw_fire) && !commit;
            w_held  <= (w_held || w_fire) && !commit;
            if (aw_fire) aw_idx_q <= aw_addr_i[AXI_ADDR_WIDTH-1:OFF];
            if (w_fire) begin
                w_data_q <= w_data_i;
                w_strb_q <= w_strb_i;
            end
            if (commit) b_resp_o <= w_err ? 2'b10 : 2'b00;
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < SW; k++)
                    if (commit && !w_err && w_idx == IW'(i) && w_strb[k])
                        regs[i][8*k +: 8] <= w_data[8*k +: 8];
        end
    end

    always_comb begin
        ar_ready_o = r_state == R_IDLE && !rst_i;
        r_valid_o  = r_state == R_RESP;
        ar_fire    = ar_valid_i && ar_ready_o;
        r_idx      = ar_addr_i[AXI_ADDR_WIDTH-1:OFF];
        r_err      = 32'(r_idx) >= NUM_REGS;
        r_state_n  = r_state == R_IDLE ? (ar_fire ? R_RESP : R_IDLE) : (r_ready_i ? R_IDLE : R_RESP);
    end

    // Reads sample regs before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= R_IDLE;
            r_data_o <= '0;
            r_resp_o <= 2'b00;
        end else begin
            r_state <= r_state_n;
            if (ar_fire) begin
                r_data_o <= r_err ? '0 : regs[r_idx];
                r_resp_o <= r_err ? 2'b10 : 2'b00;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_o[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
    end
endmodule

// File: tb/tb_axi_lite_regfile_slv.sv
// tb_axi_lite_regfile_slv: randomized bench for axi_lite_regfile_slv (3 regs, so byte address 6 is out of range).
module tb_axi_lite_regfile_slv;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] aw_addr = '0, ar_addr = '0;
    logic aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0, b_ready = 1'b0, r_ready = 1'b0;
    logic [15:0] w_data = '0;
    logic [1:0] w_strb = '0;
    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0] b_resp, r_resp;
    logic [15:0] r_data;
    logic [47:0] reg_o;
    logic [15:0] mdl [3];
    int n_tests = 0, n_fail = 0;

    axi_lite_regfile_slv #(.AXI_ADDR_WIDTH(3), .AXI_DATA_WIDTH(16), .NUM_REGS(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_prot_i(3'b000), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(3'b000), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .reg_o(reg_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mdl_flat();
        return {mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s,
                            input int awd, input int wd, input int bd);
        int t = 0, idx = int'(a) / 2;
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        while (!(aw_done && w_done) && t < 40) begin
            aw_valid = !aw_done && t >= awd;
            aw_addr = a;
            w_valid = !w_done && t >= wd;
            w_data = d;
            w_strb = s;
            @(negedge clk);
            check("b_valid_early", b_valid, 0);
            if (aw_done) check("aw_ready_held", aw_ready, 0);
            if (w_done) check("w_ready_held", w_ready, 0);
            aw_f = aw_valid && aw_ready;
            w_f = w_valid && w_ready;
            @(posedge clk);
            #1;
            aw_done |= aw_f;
            w_done |= w_f;
            t++;
        end
        aw_valid = 0;
        w_valid = 0;
        check("write_handshake", {aw_done, w_done}, 2'b11);
        check("b_valid", b_valid, 1);
        check("b_resp", b_resp, idx >= 3 ? 2'b10 : 2'b00);
        if (idx < 3)
            for (int k = 0; k < 2; k++)
                if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
        for (int i = 0; i < bd; i++) begin
            @(negedge clk);
            check("b_hold_valid", b_valid, 1);
            check("b_hold_resp", b_resp, idx >= 3 ? 2'b10 : 2'b00);
            check("b_hold_readies", {aw_ready, w_ready}, 2'b00);
        end
        b_ready = 1;
        @(posedge clk);
        #1;
        b_ready = 0;
        check("b_done", b_valid, 0);
        check("reg_o_after_wr", reg_o, mdl_flat());
    endtask

    task automatic do_read(input logic [2:0] a, input int ard, input int rd);
        int t = 0, idx = int'(a) / 2;
        bit done = 0;
        logic [15:0] ed = idx >= 3 ? 16'h0 : mdl[idx];
        logic [1:0] er = idx >= 3 ? 2'b10 : 2'b00;
        for (int i = 0; i < ard; i++) begin
            @(posedge clk);
            #1;
        end
        ar_valid = 1;
        ar_addr = a;
        while (!done && t < 20) begin
            @(negedge clk);
            check("r_valid_early", r_valid, 0);
            done = ar_ready;
            @(posedge clk);
            #1;
            t++;
        end
        ar_valid = 0;
        check("r_valid", r_valid, 1);
        check("r_data", r_data, ed);
        check("r_resp", r_resp, er);
        for (int i = 0; i < rd; i++) begin
            @(negedge clk);
            check("r_hold", {r_valid, r_resp, r_data}, {1'b1, er, ed});
            check("r_hold_ar_ready", ar_ready, 0);
        end
        r_ready = 1;
        @(posedge clk);
        #1;
        r_ready = 0;
        check("r_done", r_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, reg_o}, '0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mdl[i] = '0;
        #12;
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", {aw_ready, w_ready, ar_ready}, 3'b111);
        @(posedge clk);
        #1;
        do_write(3'h2, 16'hBEEF, 2'b11, 0, 0, 0);
        do_read(3'h2, 0, 0);
        do_write(3'h4, 16'hABCD, 2'b11, 1, 0, 0);
        do_write(3'h4, 16'h1234, 2'b01, 3, 0, 0);
        check("strobe_merge", reg_o[47:32], 16'hAB34);
        do_write(3'h6, 16'hFFFF, 2'b11, 0, 2, 0);
        do_read(3'h6, 0, 0);
        do_write(3'h3, 16'h0F0F, 2'b10, 0, 0, 5);
        do_read(3'h5, 0, 5);
        do_write(3'h0, 16'h9999, 2'b00, 0, 0, 0);
        // read and write of reg0 handshake together
        aw_valid = 1; aw_addr = 3'h0; w_valid = 1; w_data = 16'h5555; w_strb = 2'b11;
        ar_valid = 1; ar_addr = 3'h0;
        @(negedge clk);
        check("collide_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
        @(posedge clk);
        #1;
        aw_valid = 0; w_valid = 0; ar_valid = 0;
        check("collide_r_old", {r_valid, r_data}, {1'b1, 16'h0000});
        check("collide_b", {b_valid, b_resp}, 3'b100);
        mdl[0] = 16'h5555;
        b_ready = 1; r_ready = 1;
        @(posedge clk);
        #1;
        b_ready = 0; r_ready = 0;
        do_read(3'h1, 0, 0);
        check("collide_new", r_data, 16'h5555);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        // reset while both responses are pending
        aw_valid = 1; aw_addr = 3'h2; w_valid = 1; w_data = 16'h7777; w_strb = 2'b11;
        ar_valid = 1; ar_addr = 3'h2;
        @(posedge clk);
        #1;
        aw_valid = 0; w_valid = 0; ar_valid = 0;
        check("pending_valids", {b_valid, r_valid}, 2'b11);
        #2;
        rst = 1;
        #1;
        check_all_zero("midtxn_reset");
        for (int i = 0; i < 3; i++) mdl[i] = '0;
        @(posedge clk);
        #1;
        rst = 0;
        do_read(3'h2, 0, 0);
        do_write(3'h0, 16'h1357, 2'b11, 0, 0, 0);
        do_read(3'h0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
